// File: rtl/pipeline_seq_mc.sv
// pipeline_seq_mc
//
// Multi-lane frame sequencer sitting between the audio sample source and the
// DSP core. Frames of n_lanes signed samples are queued in a small input FIFO.
// In core mode each lane is issued to the core with a one-cycle tick and the
// lane results are gathered into an output frame. In bypass mode the frame is
// forwarded unchanged. Dropped input frames are counted, a watchdog guards each
// core transaction, and a watchdog expiry parks the block in a sticky fault
// state until software clears it.
//
// Ports:
//   clk, reset          single clock, asynchronous active-high reset
//   enable              1 = route through core, 0 = bypass (sampled at pop)
//   clear_error         leaves FAULT, ignored elsewhere
//   in_sample/in_valid  input frame (lane k at [k*data_width +: data_width])
//   in_ready            FIFO not full and not in FAULT
//   out_sample          output frame, same packing, held between pulses
//   out_valid           one-cycle pulse qualifying out_sample
//   core_tick           one-cycle start pulse to the core
//   core_sample_in      lane sample sent to the core
//   core_lane           index of the lane being processed
//   core_sample_out     core result
//   core_ready          core result valid / core idle
//   overrun             one-cycle pulse per dropped input frame
//   overrun_count       saturating count of dropped frames
//   frame_ctr           wrapping count of emitted frames
//   error               high while in FAULT
module pipeline_seq_mc #(
    parameter int data_width     = 16,
    parameter int n_lanes        = 2,
    parameter int fifo_depth     = 4,
    parameter int timeout_cycles = 4096,
    localparam int lane_w        = (n_lanes > 1) ? $clog2(n_lanes) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               clear_error,
    input  logic [n_lanes*data_width-1:0]      in_sample,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [n_lanes*data_width-1:0]      out_sample,
    output logic                               out_valid,
    output logic                               core_tick,
    output logic signed [data_width-1:0]       core_sample_in,
    output logic [lane_w-1:0]                  core_lane,
    input  logic signed [data_width-1:0]       core_sample_out,
    input  logic                               core_ready,
    output logic                               overrun,
    output logic [15:0]                        overrun_count,
    output logic [31:0]                        frame_ctr,
    output logic                               error
);

    localparam int frame_w = n_lanes * data_width;
    localparam int ptr_w   = $clog2(fifo_depth);
    localparam int cnt_w   = ptr_w + 1;
    localparam int wd_w    = $clog2(timeout_cycles + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        WAIT,
        EMIT,
        FAULT
    } state_t;

    state_t             state;
    logic [frame_w-1:0] fifo_mem [fifo_depth];
    logic [ptr_w-1:0]   wr_ptr;
    logic [ptr_w-1:0]   rd_ptr;
    logic [cnt_w-1:0]   count;
    logic [lane_w-1:0]  lane;
    logic [wd_w-1:0]    wd;
    logic [frame_w-1:0] work_frame;
    logic [frame_w-1:0] acc_frame;
    logic [frame_w-1:0] head;
    logic               full;
    logic               push;
    logic               drop;
    logic               pop;

    function automatic logic signed [data_width-1:0] get_lane(
        input logic [frame_w-1:0] f,
        input logic [lane_w-1:0]  idx
    );
        logic signed [data_width-1:0] s;
        s = '0;
        for (int k = 0; k < n_lanes; k++) begin
            if (idx == lane_w'(k)) s = f[k*data_width +: data_width];
        end
        return s;
    endfunction

    function automatic logic [frame_w-1:0] put_lane(
        input logic [frame_w-1:0]           f,
        input logic [lane_w-1:0]            idx,
        input logic signed [data_width-1:0] s
    );
        logic [frame_w-1:0] r;
        r = f;
        for (int k = 0; k < n_lanes; k++) begin
            if (idx == lane_w'(k)) r[k*data_width +: data_width] = s;
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Fullness is judged on the registered count only, so a push against a
    // full FIFO is dropped even if the head is popped in the same cycle.
    assign full     = (count == cnt_w'(fifo_depth));
    assign in_ready = !reset && !full && (state != FAULT);
    assign push     = in_valid && in_ready;
    assign drop     = in_valid && !in_ready;
    assign pop      = (state == IDLE) && (count != '0);
    assign head     = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= in_sample;
    end

    // Working frame and lane accumulator are pure data and need no reset:
    // every lane of acc_frame is written before it is ever emitted.
    always_ff @(posedge clk) begin
        if (pop) work_frame <= head;
        if (state == WAIT && core_ready) acc_frame <= put_lane(acc_frame, lane, core_sample_out);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            lane           <= '0;
            wd             <= '0;
            out_valid      <= 1'b0;
            out_sample     <= '0;
            core_tick      <= 1'b0;
            core_sample_in <= '0;
            core_lane      <= '0;
            overrun        <= 1'b0;
            overrun_count  <= '0;
            frame_ctr      <= '0;
            error          <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            core_tick <= 1'b0;
            overrun   <= drop;
            if (drop) overrun_count <= sat_inc16(overrun_count);

            if (state == FAULT) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + ptr_w'(1);
                if (pop)  rd_ptr <= rd_ptr + ptr_w'(1);
                case ({push, pop})
                    2'b10:   count <= count + cnt_w'(1);
                    2'b01:   count <= count - cnt_w'(1);
                    default: ;
                endcase
            end

            // Outputs are registered: each pulse is raised on the transition
            // into the state that owns it.
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (enable) begin
                            lane           <= '0;
                            core_tick      <= 1'b1;
                            core_sample_in <= get_lane(head, lane_w'(0));
                            core_lane      <= '0;
                            state          <= ISSUE;
                        end else begin
                            out_sample <= head;
                            out_valid  <= 1'b1;
                            frame_ctr  <= frame_ctr + 32'd1;
                            state      <= EMIT;
                        end
                    end
                end
                ISSUE: begin
                    wd    <= '0;
                    state <= GUARD;
                end
                GUARD: begin
                    // core_ready lags the tick by a cycle, so it is not trusted here
                    wd    <= wd + wd_w'(1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (core_ready) begin
                        if (lane == lane_w'(n_lanes - 1)) begin
                            out_sample <= put_lane(acc_frame, lane, core_sample_out);
                            out_valid  <= 1'b1;
                            frame_ctr  <= frame_ctr + 32'd1;
                            state      <= EMIT;
                        end else begin
                            lane           <= lane + lane_w'(1);
                            core_tick      <= 1'b1;
                            core_sample_in <= get_lane(work_frame, lane + lane_w'(1));
                            core_lane      <= lane + lane_w'(1);
                            state          <= ISSUE;
                        end
                    end else if (wd == wd_w'(timeout_cycles - 1)) begin
                        // this cycle's increment would reach the timeout
                        error <= 1'b1;
                        state <= FAULT;
                    end else begin
                        wd <= wd + wd_w'(1);
                    end
                end
                EMIT: begin
                    state <= IDLE;
                end
                FAULT: begin
                    // clear_error is only seen once FAULT is the registered
                    // state, so FAULT always lasts at least one cycle
                    if (clear_error) begin
                        error <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
